// File: rtl/match_fsm.sv
// rtl/match_fsm.sv - pong match controller: mode FSM, game/menu tick strobes, scoring
module match_fsm #(
  parameter int GAME_DIV    = 4,
  parameter int MENU_DIV    = 8,
  parameter int SERVE_DELAY = 16,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_enter,
  input  logic               i_value,
  input  logic               i_goal_1,
  input  logic               i_goal_2,
  output logic               o_tick_game,
  output logic               o_tick_menu,
  output logic               o_enable_start,
  output logic               o_enable_pause,
  output logic               o_enable_game,
  output logic               o_round_reset,
  output logic [SCORE_W-1:0] o_score_1,
  output logic [SCORE_W-1:0] o_score_2,
  output logic [1:0]         o_winner,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    ST_START = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int GW = $clog2(GAME_DIV);
  localparam int MW = $clog2(MENU_DIV);
  localparam int SW = $clog2(SERVE_DELAY + 1);
  localparam logic [GW-1:0]      GAME_LAST  = GW'(GAME_DIV - 1);
  localparam logic [MW-1:0]      MENU_LAST  = MW'(MENU_DIV - 1);
  localparam logic [SW-1:0]      SERVE_LAST = SW'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

  state_t             r_state;
  logic               r_enter_q;
  logic               r_ret_play;
  logic [GW-1:0]      r_game_cnt;
  logic [MW-1:0]      r_menu_cnt;
  logic [SW-1:0]      r_serve_cnt;
  logic [SCORE_W-1:0] r_score_1;
  logic [SCORE_W-1:0] r_score_2;
  logic [1:0]         r_winner;

  state_t             w_next;
  logic               w_press;
  logic               w_stay;
  logic               w_menu_mode;
  logic               w_ret_play_nx;
  logic [SW-1:0]      w_serve_nx;
  logic [SCORE_W-1:0] w_score_1_nx;
  logic [SCORE_W-1:0] w_score_2_nx;
  logic [SCORE_W-1:0] w_s1_inc;
  logic [SCORE_W-1:0] w_s2_inc;
  logic [1:0]         w_winner_nx;

  assign w_press     = i_enter & ~r_enter_q;
  assign w_s1_inc    = r_score_1 + 1'b1;
  assign w_s2_inc    = r_score_2 + 1'b1;
  assign w_stay      = (w_next == r_state);
  assign w_menu_mode = (r_state == ST_START) || (r_state == ST_PAUSE) || (r_state == ST_OVER);

  always_comb begin
    w_next        = r_state;
    w_ret_play_nx = r_ret_play;
    w_serve_nx    = r_serve_cnt;
    w_score_1_nx  = r_score_1;
    w_score_2_nx  = r_score_2;
    w_winner_nx   = r_winner;
    case (r_state)
      ST_START: if (w_press) begin
        w_next       = ST_SERVE;
        w_serve_nx   = '0;
        w_score_1_nx = '0;
        w_score_2_nx = '0;
        w_winner_nx  = 2'b00;
      end
      ST_SERVE: begin
        // A press freezes the serve countdown; it resumes from the same count.
        if (w_press) begin
          w_next        = ST_PAUSE;
          w_ret_play_nx = 1'b0;
        end else if (r_serve_cnt == SERVE_LAST) begin
          w_next = ST_PLAY;
        end else begin
          w_serve_nx = r_serve_cnt + 1'b1;
        end
      end
      ST_PLAY: begin
        if (i_goal_1 && i_goal_2) begin
          w_next     = ST_SERVE;
          w_serve_nx = '0;
        end else if (i_goal_1) begin
          w_score_1_nx = w_s1_inc;
          w_serve_nx   = '0;
          w_next       = (w_s1_inc == WIN) ? ST_OVER : ST_SERVE;
          if (w_s1_inc == WIN) w_winner_nx = 2'b01;
        end else if (i_goal_2) begin
          w_score_2_nx = w_s2_inc;
          w_serve_nx   = '0;
          w_next       = (w_s2_inc == WIN) ? ST_OVER : ST_SERVE;
          if (w_s2_inc == WIN) w_winner_nx = 2'b10;
        end else if (w_press) begin
          w_next        = ST_PAUSE;
          w_ret_play_nx = 1'b1;
        end
      end
      ST_PAUSE: if (w_press) begin
        if (i_value) begin
          w_next       = ST_START;
          w_score_1_nx = '0;
          w_score_2_nx = '0;
          w_winner_nx  = 2'b00;
        end else begin
          w_next = r_ret_play ? ST_PLAY : ST_SERVE;
        end
      end
      ST_OVER: if (w_press) w_next = ST_START;
      default: w_next = ST_START;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_enter_q      <= 1'b0;
      r_state        <= ST_START;
      r_ret_play     <= 1'b0;
      r_serve_cnt    <= '0;
      r_game_cnt     <= '0;
      r_menu_cnt     <= '0;
      r_score_1      <= '0;
      r_score_2      <= '0;
      r_winner       <= 2'b00;
      o_tick_game    <= 1'b0;
      o_tick_menu    <= 1'b0;
      o_round_reset  <= 1'b0;
      o_enable_start <= 1'b1;
      o_enable_pause <= 1'b0;
      o_enable_game  <= 1'b0;
    end else begin
      r_enter_q   <= i_enter;
      r_state     <= w_next;
      r_ret_play  <= w_ret_play_nx;
      r_serve_cnt <= w_serve_nx;
      r_score_1   <= w_score_1_nx;
      r_score_2   <= w_score_2_nx;
      r_winner    <= w_winner_nx;
      // Tick dividers restart on any state change so the first strobe lands DIV clocks in.
      if (w_stay && r_state == ST_PLAY) begin
        r_game_cnt  <= (r_game_cnt == GAME_LAST) ? '0 : r_game_cnt + 1'b1;
        o_tick_game <= (r_game_cnt == GAME_LAST);
      end else begin
        r_game_cnt  <= '0;
        o_tick_game <= 1'b0;
      end
      if (w_stay && w_menu_mode) begin
        r_menu_cnt  <= (r_menu_cnt == MENU_LAST) ? '0 : r_menu_cnt + 1'b1;
        o_tick_menu <= (r_menu_cnt == MENU_LAST);
      end else begin
        r_menu_cnt  <= '0;
        o_tick_menu <= 1'b0;
      end
      o_round_reset  <= (w_next == ST_SERVE) && !w_stay;
      o_enable_start <= (w_next == ST_START);
      o_enable_pause <= (w_next == ST_PAUSE);
      o_enable_game  <= (w_next == ST_PLAY);
    end
  end

  assign o_score_1 = r_score_1;
  assign o_score_2 = r_score_2;
  assign o_winner  = r_winner;
  assign o_state   = r_state;

endmodule

// File: tb/tb_match_fsm.sv
// tb/tb_match_fsm.sv - self-checking bench for match_fsm: vector table, corner sequences, random vs model
module tb_match_fsm;
  localparam int GAME_DIV    = 4;
  localparam int MENU_DIV    = 8;
  localparam int SERVE_DELAY = 16;
  localparam int WIN_SCORE   = 9;

  logic clk = 1'b0;
  logic rst = 1'b1, enter = 1'b0, value = 1'b0, goal_1 = 1'b0, goal_2 = 1'b0;
  logic tick_game, tick_menu, en_start, en_pause, en_game, round_reset;
  logic [3:0] score_1, score_2;
  logic [1:0] winner;
  logic [2:0] state;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  match_fsm dut (
    .i_clock(clk), .i_reset(rst), .i_enter(enter), .i_value(value),
    .i_goal_1(goal_1), .i_goal_2(goal_2),
    .o_tick_game(tick_game), .o_tick_menu(tick_menu),
    .o_enable_start(en_start), .o_enable_pause(en_pause), .o_enable_game(en_game),
    .o_round_reset(round_reset), .o_score_1(score_1), .o_score_2(score_2),
    .o_winner(winner), .o_state(state)
  );

  // Reference model: mode plus "clocks spent in this mode" and "clocks spent serving".
  int m_state = 0, m_age = 0, m_serve = 0, m_s1 = 0, m_s2 = 0, m_win = 0, m_ret = 0;
  bit m_eq = 0, m_tg = 0, m_tm = 0, m_rr = 0;

  task automatic model_step(input bit r, input bit en, input bit val, input bit g1, input bit g2);
    int nxt;
    int old;
    bit press;
    if (r) begin
      m_state = 0; m_age = 0; m_serve = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_ret = 0;
      m_eq = 0; m_tg = 0; m_tm = 0; m_rr = 0;
      return;
    end
    old = m_state;
    press = en && !m_eq;
    m_eq = en;
    nxt = old;
    case (old)
      0: if (press) begin nxt = 1; m_s1 = 0; m_s2 = 0; m_win = 0; m_serve = 0; end
      1: begin
        if (press) begin nxt = 3; m_ret = 1; end
        else if (m_serve == SERVE_DELAY - 1) nxt = 2;
        else m_serve++;
      end
      2: begin
        if (g1 && g2) begin nxt = 1; m_serve = 0; end
        else if (g1 || g2) begin
          if (g1) m_s1++; else m_s2++;
          m_serve = 0;
          if (m_s1 == WIN_SCORE || m_s2 == WIN_SCORE) begin nxt = 4; m_win = g1 ? 1 : 2; end
          else nxt = 1;
        end else if (press) begin nxt = 3; m_ret = 2; end
      end
      3: if (press) begin
        if (val) begin nxt = 0; m_s1 = 0; m_s2 = 0; m_win = 0; end
        else nxt = m_ret;
      end
      default: if (press) nxt = 0;
    endcase
    m_rr  = (nxt == 1) && (old != 1);
    m_age = (nxt == old) ? m_age + 1 : 0;
    m_tg  = (nxt == 2) && (m_age > 0) && (m_age % GAME_DIV == 0);
    m_tm  = (nxt == 0 || nxt == 3 || nxt == 4) && (m_age > 0) && (m_age % MENU_DIV == 0);
    m_state = nxt;
  endtask

  task automatic check(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d expected=%0d at %0t", name, got, exp, $time);
  endtask

  task automatic cyc(input bit r, input bit en, input bit val, input bit g1, input bit g2);
    logic [18:0] got, exp;
    @(negedge clk);
    rst = r; enter = en; value = val; goal_1 = g1; goal_2 = g2;
    model_step(r, en, val, g1, g2);
    @(posedge clk);
    #1;
    got = {state, tick_game, tick_menu, en_start, en_pause, en_game, round_reset,
           score_1, score_2, winner};
    exp = {3'(m_state), m_tg, m_tm, m_state == 0, m_state == 3, m_state == 2, m_rr,
           4'(m_s1), 4'(m_s2), 2'(m_win)};
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL model got=%h expected=%h at %0t", got, exp, $time);
  endtask

  task automatic wait_play(input int budget);
    int k;
    k = 0;
    while (m_state != 2 && k < budget) begin
      cyc(0, 0, 0, 0, 0);
      k++;
    end
    check("wait_play_timeout", int'(m_state == 2), 1);
  endtask

  typedef struct {
    bit r, en, val, g1, g2;
    int n;
    int st;
    bit rr, tg, tm;
    int s1, s2, win;
  } vec_t;

  vec_t tbl[9];

  initial begin
    tbl[0] = '{1, 0, 0, 0, 0,  2, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{0, 1, 0, 0, 0,  1, 1, 1, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 0, 0, 14, 1, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{0, 0, 0, 0, 0,  1, 2, 0, 0, 0, 0, 0, 0};
    tbl[5] = '{0, 0, 0, 0, 0,  3, 2, 0, 0, 0, 0, 0, 0};
    tbl[6] = '{0, 0, 0, 0, 0,  1, 2, 0, 1, 0, 0, 0, 0};
    tbl[7] = '{0, 0, 0, 0, 0,  3, 2, 0, 0, 0, 0, 0, 0};
    tbl[8] = '{0, 0, 0, 0, 0,  1, 2, 0, 1, 0, 0, 0, 0};

    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < tbl[i].n; j++) cyc(tbl[i].r, tbl[i].en, tbl[i].val, tbl[i].g1, tbl[i].g2);
      check($sformatf("vec%0d_state", i), int'(state), tbl[i].st);
      check($sformatf("vec%0d_flags", i), int'({round_reset, tick_game, tick_menu}),
            int'({tbl[i].rr, tbl[i].tg, tbl[i].tm}));
      check($sformatf("vec%0d_scores", i), int'({score_1, score_2, winner}),
            (tbl[i].s1 << 6) | (tbl[i].s2 << 2) | tbl[i].win);
    end

    // Player 1 wins 9-0, then menu ticks in OVER.
    for (int k = 1; k <= 9; k++) begin
      wait_play(40);
      cyc(0, 0, 0, 1, 0);
      check("win_score_1", int'(score_1), k);
      check("win_state", int'(state), (k < 9) ? 1 : 4);
    end
    check("win_winner", int'(winner), 1);
    for (int j = 1; j <= 16; j++) begin
      cyc(0, 0, 0, 0, 0);
      check("over_tick_menu", int'(tick_menu), int'(j % 8 == 0));
    end
    cyc(0, 1, 0, 0, 0);
    check("over_to_start", int'(state), 0);
    check("start_scores_held", int'(score_1), 9);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("restart_scores", int'({score_1, winner}), 0);
    cyc(0, 0, 0, 0, 0);

    // Simultaneous goals replay the point.
    wait_play(40);
    cyc(0, 0, 0, 1, 0);
    wait_play(40);
    cyc(0, 0, 0, 1, 1);
    check("tie_state", int'(state), 1);
    check("tie_round_reset", int'(round_reset), 1);
    check("tie_scores", int'({score_1, score_2}), 8'h10);

    // Pause during serve keeps the serve count.
    for (int j = 0; j < 5; j++) cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("serve_pause", int'(state), 3);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    check("pause_resume_serve", int'(state), 1);
    for (int j = 1; j <= 11; j++) begin
      cyc(0, 0, 0, 0, 0);
      if (j >= 10) check("serve_resume_len", int'(state), (j == 11) ? 2 : 1);
    end

    // Quit from pause, then a held button counts once.
    cyc(0, 1, 0, 0, 0);
    check("play_pause", int'(state), 3);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0);
    check("quit_state", int'(state), 0);
    check("quit_scores", int'({score_1, score_2}), 0);
    cyc(0, 0, 0, 0, 0);
    for (int j = 1; j <= 20; j++) begin
      cyc(0, 1, 0, 0, 0);
      if (j == 1) check("held_press", int'(state), 1);
    end
    check("held_single", int'(state), 2);
    cyc(0, 0, 0, 0, 0);

    // Reset wins over a goal in the same cycle.
    wait_play(40);
    cyc(1, 0, 0, 0, 1);
    check("rst_goal_state", int'(state), 0);
    check("rst_goal_score", int'(score_2), 0);
    check("rst_goal_strobes", int'({tick_game, tick_menu, round_reset}), 0);
    cyc(0, 0, 0, 0, 0);

    // Random traffic against the model.
    begin
      bit en_r;
      en_r = 0;
      for (int j = 0; j < 4000; j++) begin
        if ($urandom_range(3) == 0) en_r = ~en_r;
        cyc($urandom_range(499) == 0, en_r, 1'($urandom_range(1)),
            $urandom_range(9) == 0, $urandom_range(9) == 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
